// File: rtl/debug_dump_tx_pkg.sv
// Shared types and constants for the debug dump transmitter: FSM states,
// frame section identifiers, header value and default section lengths.
package debug_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_MEM_ADDR,
    S_MEM_WAIT,
    S_FINISH
  } state_t;

  typedef enum logic [3:0] {
    SEC_HDR,
    SEC_PC,
    SEC_REGS,
    SEC_IF_ID,
    SEC_ID_EX,
    SEC_EX_MEM,
    SEC_MEM_WB,
    SEC_MEM,
    SEC_CKSUM
  } section_t;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Bytes needed to carry a field of the given bit width, zero-padded.
  function automatic int bytes_of(input int width);
    return (width + 7) / 8;
  endfunction

  // Section lengths of the default-parameter frame (host-side reference).
  localparam int HDR_BYTES    = 1;
  localparam int PC_BYTES     = bytes_of(32);
  localparam int REGS_BYTES   = 32 * bytes_of(32);
  localparam int IF_ID_BYTES  = bytes_of(64);
  localparam int ID_EX_BYTES  = bytes_of(129);
  localparam int EX_MEM_BYTES = bytes_of(78);
  localparam int MEM_WB_BYTES = bytes_of(72);
  localparam int MEM_BYTES    = 64 * bytes_of(32);

endpackage

// File: rtl/debug_dump_tx_if.sv
// UART TX handshake and data-memory debug read port of the dump engine.
// master = dump engine, slave = UART core / memory side.
interface debug_dump_tx_if #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_done;
  logic [ADDR_WIDTH-1:0] debug_addr;
  logic [SIZE-1:0]       debug_data;

  modport master (
    output tx_data, tx_start, debug_addr,
    input  tx_done, debug_data
  );

  modport slave (
    input  tx_data, tx_start, debug_addr,
    output tx_done, debug_data
  );
endinterface

// File: rtl/debug_dump_tx_byte_sel.sv
// dump_byte_sel: combinational pick of byte i_idx from a byte-packed vector;
// out-of-range indices return 0.
module dump_byte_sel #(
  parameter int NUM_BYTES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [8*NUM_BYTES-1:0] i_vec,
  input  logic [IDX_W-1:0]       i_idx,
  output logic [7:0]             o_byte
);
  always_comb begin
    o_byte = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (32'(i_idx) == b) o_byte = i_vec[8*b +: 8];
    end
  end
endmodule

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: serialises a frozen processor snapshot plus data memory into a
// fixed little-endian UART frame. Define DEBUG_DUMP_CHECKSUM_EN for an XOR trailer byte.
module debug_dump_tx #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int MEM_SIZE      = 64,
  parameter int ADDR_WIDTH    = $clog2(MEM_SIZE),
  parameter int IF_ID_SIZE    = 64,
  parameter int ID_EX_SIZE    = 129,
  parameter int EX_MEM_SIZE   = 78,
  parameter int MEM_WB_SIZE   = 72,
  parameter logic [7:0] HEADER_BYTE = debug_pkg::HEADER_BYTE
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [SIZE-1:0]               i_pc,
  input  logic [NUM_REGISTERS*SIZE-1:0] i_registers_debug,
  input  logic [IF_ID_SIZE-1:0]         i_IF_ID,
  input  logic [ID_EX_SIZE-1:0]         i_ID_EX,
  input  logic [EX_MEM_SIZE-1:0]        i_EX_MEM,
  input  logic [MEM_WB_SIZE-1:0]        i_MEM_WB,
  output logic                          o_busy,
  output logic                          o_done,
  debug_dump_tx_if.master               bus
);
  import debug_pkg::*;

  localparam int WORD_B     = bytes_of(SIZE);
  localparam int PC_OFF     = 1;
  localparam int REGS_OFF   = PC_OFF + WORD_B;
  localparam int IF_ID_OFF  = REGS_OFF + NUM_REGISTERS * WORD_B;
  localparam int ID_EX_OFF  = IF_ID_OFF + bytes_of(IF_ID_SIZE);
  localparam int EX_MEM_OFF = ID_EX_OFF + bytes_of(ID_EX_SIZE);
  localparam int MEM_WB_OFF = EX_MEM_OFF + bytes_of(EX_MEM_SIZE);
  localparam int MEM_OFF    = MEM_WB_OFF + bytes_of(MEM_WB_SIZE);
  localparam int CKSUM_OFF  = MEM_OFF + MEM_SIZE * WORD_B;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int TRAILER_B  = 1;
`else
  localparam int TRAILER_B  = 0;
`endif
  localparam int FRAME_BYTES = CKSUM_OFF + TRAILER_B;
  localparam int SNAP_BYTES  = MEM_OFF;
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
  localparam int SNAP_IDX_W  = $clog2(SNAP_BYTES);
  localparam int WB_W        = (WORD_B > 1) ? $clog2(WORD_B) : 1;
  localparam int K_W         = $clog2(MEM_SIZE + 1);
  localparam logic [WB_W-1:0] WB_LAST = WB_W'(WORD_B - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [WB_W-1:0]         wbyte_q, wbyte_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic [ADDR_WIDTH-1:0]   debug_addr_q, debug_addr_d;
  logic [8*SNAP_BYTES-1:0] snap_q, snap_d;
  logic [SIZE-1:0]         word_q, word_d;

  logic        capture;
  logic [31:0] bc;
  section_t    sec;
  logic [7:0]  snap_byte, word_byte, load_byte;

  assign capture = (state_q == S_IDLE) && i_start;
  assign bc      = 32'(byte_cnt_q);

  // Header, PC, registers and latches as one byte-packed, zero-padded vector.
  always_comb begin
    snap_d = snap_q;
    if (capture) begin
      snap_d = '0;
      snap_d[7:0] = HEADER_BYTE;
      snap_d[8*PC_OFF +: SIZE]                     = i_pc;
      snap_d[8*REGS_OFF +: NUM_REGISTERS*SIZE]     = i_registers_debug;
      snap_d[8*IF_ID_OFF +: IF_ID_SIZE]            = i_IF_ID;
      snap_d[8*ID_EX_OFF +: ID_EX_SIZE]            = i_ID_EX;
      snap_d[8*EX_MEM_OFF +: EX_MEM_SIZE]          = i_EX_MEM;
      snap_d[8*MEM_WB_OFF +: MEM_WB_SIZE]          = i_MEM_WB;
    end
  end

  // NOTE: snapshot and word buffer are pure data written before use, so they carry no reset.
  always_ff @(posedge i_clk) begin
    snap_q <= snap_d;
    word_q <= word_d;
  end

  always_comb begin
    sec = SEC_HDR;
    if      (bc >= 32'(CKSUM_OFF))  sec = SEC_CKSUM;
    else if (bc >= 32'(MEM_OFF))    sec = SEC_MEM;
    else if (bc >= 32'(MEM_WB_OFF)) sec = SEC_MEM_WB;
    else if (bc >= 32'(EX_MEM_OFF)) sec = SEC_EX_MEM;
    else if (bc >= 32'(ID_EX_OFF))  sec = SEC_ID_EX;
    else if (bc >= 32'(IF_ID_OFF))  sec = SEC_IF_ID;
    else if (bc >= 32'(REGS_OFF))   sec = SEC_REGS;
    else if (bc >= 32'(PC_OFF))     sec = SEC_PC;
  end

  dump_byte_sel #(.NUM_BYTES(SNAP_BYTES), .IDX_W(SNAP_IDX_W)) u_snap_sel (
    .i_vec  (snap_q),
    .i_idx  (byte_cnt_q[SNAP_IDX_W-1:0]),
    .o_byte (snap_byte)
  );

  dump_byte_sel #(.NUM_BYTES(WORD_B), .IDX_W(WB_W)) u_word_sel (
    .i_vec  (word_q),
    .i_idx  (wbyte_q),
    .o_byte (word_byte)
  );

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (capture)                 cksum_d = '0;
    else if (state_q == S_SEND)  cksum_d = cksum_q ^ tx_data_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end
`endif

  always_comb begin
    load_byte = snap_byte;
    case (sec)
      SEC_MEM:   load_byte = word_byte;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      SEC_CKSUM: load_byte = cksum_q;
`endif
      default:   ;
    endcase
  end

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    k_d          = k_q;
    wbyte_d      = wbyte_q;
    tx_data_d    = tx_data_q;
    debug_addr_d = debug_addr_q;
    word_d       = word_q;
    case (state_q)
      S_IDLE: begin
        debug_addr_d = '0;
        if (i_start) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
          k_d        = '0;
          wbyte_d    = '0;
        end
      end
      S_LOAD: begin
        tx_data_d = load_byte;
        state_d   = S_SEND;
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.tx_done) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (sec == SEC_MEM) wbyte_d = (wbyte_q == WB_LAST) ? '0 : wbyte_q + 1'b1;
          if (bc == 32'(FRAME_BYTES - 1)) begin
            state_d = S_FINISH;
          end else if (bc == 32'(MEM_OFF - 1) ||
                       (sec == SEC_MEM && wbyte_q == WB_LAST && bc != 32'(CKSUM_OFF - 1))) begin
            // Address is presented for all of MEM_ADDR so the read has a full cycle.
            state_d      = S_MEM_ADDR;
            debug_addr_d = k_q[ADDR_WIDTH-1:0];
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_MEM_ADDR: state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        word_d  = bus.debug_data;
        k_d     = k_q + 1'b1;
        state_d = S_LOAD;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      k_q          <= '0;
      wbyte_q      <= '0;
      tx_data_q    <= '0;
      debug_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      k_q          <= k_d;
      wbyte_q      <= wbyte_d;
      tx_data_q    <= tx_data_d;
      debug_addr_q <= debug_addr_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = (state_q == S_SEND);
  assign bus.debug_addr = debug_addr_q;
  assign o_busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign o_done         = (state_q == S_FINISH);

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: expected frames are built from the frame
// layout rules at i_start and compared byte-by-byte by an independent monitor.
module tb_debug_dump_tx;
  localparam int MEM_SIZE = 64;
  localparam int AW       = 6;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int FRAME_LEN = 434;
`else
  localparam int FRAME_LEN = 433;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   pc;
  logic [1023:0] regs;
  logic [63:0]   if_id;
  logic [128:0]  id_ex;
  logic [77:0]   ex_mem;
  logic [71:0]   mem_wb;
  logic          busy, done;

  debug_dump_tx_if #(.SIZE(32), .ADDR_WIDTH(AW)) bus ();

  debug_dump_tx dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_start           (start),
    .i_pc              (pc),
    .i_registers_debug (regs),
    .i_IF_ID           (if_id),
    .i_ID_EX           (id_ex),
    .i_EX_MEM          (ex_mem),
    .i_MEM_WB          (mem_wb),
    .o_busy            (busy),
    .o_done            (done),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  // Data memory with one-cycle registered read.
  logic [31:0] mem_arr [MEM_SIZE];
  always @(posedge clk) bus.debug_data <= mem_arr[bus.debug_addr];

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  rx [FRAME_LEN];
  int          rx_cnt = 0;
  logic [AW-1:0] addr_log [$];
  int          ack_delay = 5;
  int          tx_cnt;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // UART model: tx_done pulses ack_delay cycles after each tx_start.
  initial begin
    bus.tx_done = 1'b0;
    tx_cnt = 0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (rst) tx_cnt = 0;
      else begin
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) bus.tx_done = 1'b1;
        end
        if (bus.tx_start) tx_cnt = ack_delay;
      end
    end
  end

  // Monitor: compares every transmitted byte and frame completion.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        check("tx_expected", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) check($sformatf("byte[%0d]", rx_cnt), bus.tx_data, exp_q.pop_front());
        if (rx_cnt < FRAME_LEN) rx[rx_cnt] = bus.tx_data;
        rx_cnt++;
      end
      if (busy && (addr_log.size() == 0 || addr_log[$] != bus.debug_addr))
        addr_log.push_back(bus.debug_addr);
      if (done) begin
        check("frame_len", rx_cnt, FRAME_LEN);
        check("queue_drained", exp_q.size(), 0);
        check("busy_low_at_done", busy, 1'b0);
      end
    end
  end

  function automatic logic [1023:0] rand_wide();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic rand_inputs();
    logic [1023:0] t;
    pc   = $urandom;
    regs = rand_wide();
    t = rand_wide(); if_id  = t[63:0];
    t = rand_wide(); id_ex  = t[128:0];
    t = rand_wide(); ex_mem = t[77:0];
    t = rand_wide(); mem_wb = t[71:0];
  endtask

  task automatic push_bytes(input logic [1023:0] v, input int width);
    for (int i = 0; i < (width + 7) / 8; i++) exp_q.push_back(v[8*i +: 8]);
  endtask

  // Reference frame straight from the layout: header, fields LSB-first, memory, trailer.
  task automatic build_expected();
    exp_q.push_back(8'hA5);
    push_bytes(pc, 32);
    push_bytes(regs, 1024);
    push_bytes(if_id, 64);
    push_bytes(id_ex, 129);
    push_bytes(ex_mem, 78);
    push_bytes(mem_wb, 72);
    for (int k = 0; k < MEM_SIZE; k++) push_bytes(mem_arr[k], 32);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
    end
`endif
  endtask

  task automatic start_frame();
    @(negedge clk);
    check("idle_before_start", busy, 1'b0);
    exp_q.delete();
    addr_log.delete();
    rx_cnt = 0;
    build_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit mutate, input int restart_at);
    bit busy_ok = 1'b1;
    bit pulsed  = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (c == 0 && mutate) rand_inputs();
      if (restart_at >= 0 && !pulsed && rx_cnt >= restart_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("done_seen", done, 1'b1);
    check("busy_held", busy_ok, 1'b1);
  endtask

  task automatic check_addr_walk();
    int first_bad = -1;
    check("addr_steps", addr_log.size(), MEM_SIZE);
    foreach (addr_log[i]) if (first_bad < 0 && 32'(addr_log[i]) != i) first_bad = i;
    check("addr_order_first_bad", first_bad, -1);
  endtask

  initial begin
    logic [71:0] ffs;
    rst = 1'b1; start = 1'b0;
    pc = '0; regs = '0; if_id = '0; id_ex = '0; ex_mem = '0; mem_wb = '0;
    for (int k = 0; k < MEM_SIZE; k++) mem_arr[k] = 32'(k * 4 + 1);
    repeat (3) @(negedge clk);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_tx_start", bus.tx_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_debug_addr", bus.debug_addr, 6'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame A: directed values at fixed offsets.
    rand_inputs();
    pc = 32'h0000_0010;
    regs[63:32] = 32'hDEAD_BEEF;
    ex_mem = {78{1'b1}};
    start_frame();
    wait_done(1'b0, -1);
    check("hdr_pc_bytes", {rx[0], rx[1], rx[2], rx[3], rx[4]}, 40'hA5_10_00_00_00);
    check("reg1_bytes", {rx[12], rx[11], rx[10], rx[9]}, 32'hDEAD_BEEF);
    for (int i = 0; i < 9; i++) ffs[8*i +: 8] = rx[158 + i];
    check("ex_mem_ff", ffs, {9{8'hFF}});
    check("ex_mem_top", rx[167], 8'h3F);
    for (int k = 0; k < MEM_SIZE; k++)
      check($sformatf("mem_word[%0d]", k),
            {rx[180+4*k], rx[179+4*k], rx[178+4*k], rx[177+4*k]}, 32'(k * 4 + 1));
    check_addr_walk();
`ifdef DEBUG_DUMP_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 433; i++) x ^= rx[i];
      check("cksum_trailer", rx[433], x);
    end
`endif

    // Frame B: inputs change after capture, i_start pulsed mid-frame and at o_done.
    for (int k = 0; k < MEM_SIZE; k++) mem_arr[k] = $urandom;
    rand_inputs();
    ack_delay = 3;
    start_frame();
    wait_done(1'b1, 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("no_second_frame_busy", busy, 1'b0);
    check("no_second_frame_bytes", rx_cnt, FRAME_LEN);
    check_addr_walk();

    // Frame C: reset during the WAIT of byte 200.
    rand_inputs();
    ack_delay = 5;
    start_frame();
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      if (rx_cnt >= 201) break;
    end
    check("reached_byte200", 128'(rx_cnt >= 201), 128'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_tx_data", bus.tx_data, 8'h00);
    check("midrst_tx_start", bus.tx_start, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_debug_addr", bus.debug_addr, 6'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frames D and E: full random frames after the abort, varied UART latency.
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < MEM_SIZE; k++) mem_arr[k] = $urandom;
      rand_inputs();
      ack_delay = int'($urandom_range(1, 6));
      start_frame();
      wait_done(1'b0, -1);
      check("frame_hdr", rx[0], 8'hA5);
      check_addr_walk();
    end

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
